parity_gen_check: RTL and testbench
===================================

PARITY_GEN_CHECK -- requirements
Module: parity_gen_check

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width (legal range 1 to 64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the error counter width (legal range 2 to 32).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port mode_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity; sampled together with each accepted word.
REQ-006 Port in_valid, input, 1 bit: upstream word valid.
REQ-007 Port in_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 Port in_data, input, DATA_W bits: word to protect or check.
REQ-009 Port in_par, input, 1 bit: received parity bit, used only for checking.
REQ-010 Port out_valid, output, 1 bit: output register holds a word.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the output word.
REQ-012 Port out_data, output, DATA_W bits: registered copy of the accepted in_data.
REQ-013 Port out_par, output, 1 bit: generated parity bit for out_data.
REQ-014 Port out_err, output, 1 bit: in_par mismatched the generated parity for this word.
REQ-015 Port clr_err, input, 1 bit: synchronous clear of err_cnt and err_sticky.
REQ-016 Port err_cnt, output, CNT_W bits: saturating count of accepted words with a mismatch.
REQ-017 Port err_sticky, output, 1 bit: set by the first mismatch and held until clr_err or rst.

Function
REQ-018 Generated parity SHALL be (XOR of all in_data bits) XOR mode_odd, so that data plus parity has an even count of ones in even mode and an odd count in odd mode.
REQ-019 A transfer SHALL occur when in_valid and in_ready are both 1; out_data, out_par and out_err SHALL load on that edge, and out_valid SHALL be 1 on the next cycle (latency 1 cycle).
REQ-020 in_ready SHALL be (not out_valid) or out_ready, purely combinational, giving one word per cycle under continuous out_ready.
REQ-021 out_valid SHALL clear on an edge where out_ready is 1 and no new transfer occurs.
REQ-022 While out_valid is 1 and out_ready is 0, out_data, out_par and out_err SHALL hold stable.
REQ-023 out_err SHALL be in_par XOR generated parity, registered with the word.
REQ-024 err_cnt SHALL increment by 1 on each accepted word with a mismatch and saturate at all-ones without wrapping.
REQ-025 err_sticky SHALL become 1 on the edge on which a mismatching word is accepted.
REQ-026 When clr_err and a mismatching transfer occur on the same edge, the clear SHALL take priority: err_cnt becomes 0 and err_sticky becomes 0.
REQ-027 Words with in_valid 0 or in_ready 0 SHALL NOT affect err_cnt, err_sticky or the output register.
REQ-028 A change on mode_odd between transfers SHALL affect only words accepted after the change.

Reset
REQ-029 While rst is 1, out_valid, out_data, out_par, out_err, err_cnt and err_sticky SHALL all be 0, independent of clk.
REQ-030 In-flight words SHALL be discarded by reset mid-operation; in_ready SHALL be 1 from the first cycle after rst deasserts.

Structure
REQ-031 Package parity_pkg SHALL hold the default widths and a mode enumeration of EVEN=0 and ODD=1.
REQ-032 The XOR reduction SHALL be a purely combinational sub-module, parity_calc, parametrised by DATA_W; the registers, handshake and counters SHALL live in parity_gen_check.

Verification
REQ-033 Even mode, DATA_W=8, in_data=0xA5, in_par=0 -> next cycle out_valid=1, out_par=0, out_err=0, err_cnt=0.
REQ-034 Odd mode, in_data=0x01, in_par=1 -> out_par=0, out_err=1, err_cnt=1, err_sticky=1.
REQ-035 out_ready held 0 with in_valid continuously 1 -> in_ready=0 after the first word; output holds; release -> words delivered in order with none lost or duplicated.
REQ-036 CNT_W=2, five mismatching words -> err_cnt reads 1, 2, 3, 3, 3.
REQ-037 clr_err on the same edge as a mismatching transfer -> err_cnt=0, err_sticky=0, and that word still has out_err=1.
REQ-038 rst asserted mid-stream between clock edges -> all outputs 0 immediately; the first post-reset word is handled correctly.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared widths, parity mode encoding and the XOR reduction helper for the
// parity generator/checker.
package parity_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 16;
  localparam int MAX_DATA_W     = 64;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  // Parity bit for a word zero-extended to MAX_DATA_W bits; zero padding does
  // not change the XOR, so one helper serves every legal DATA_W.
  function automatic logic gen_parity(input logic [MAX_DATA_W-1:0] data,
                                      input parity_mode_e          mode);
    logic red;
    red = ^data;
    case (mode)
      EVEN:    gen_parity = red;
      ODD:     gen_parity = ~red;
      default: gen_parity = red;
    endcase
  endfunction

endpackage

// File: rtl/parity_gen_check_if.sv
// Word stream, parity and error-status signals of the parity generator/checker.
// slave is the block's view, master is the environment's view.
interface parity_gen_check_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) ();

  logic              mode_odd;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_err;
  logic              clr_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;

  modport slave (
    input  mode_odd, in_valid, in_data, in_par, out_ready, clr_err,
    output in_ready, out_valid, out_data, out_par, out_err, err_cnt, err_sticky
  );

  modport master (
    output mode_odd, in_valid, in_data, in_par, out_ready, clr_err,
    input  in_ready, out_valid, out_data, out_par, out_err, err_cnt, err_sticky
  );

endinterface

// File: rtl/parity_calc.sv
// Purely combinational parity generator: XOR of all data bits, inverted in
// odd mode so that data plus parity carries the selected ones-count parity.
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              mode_odd,
  output logic              par
);

  logic [MAX_DATA_W-1:0] ext_s;
  parity_mode_e          mode_s;

  // Zero-extend the word and decode the mode before reducing.
  always_comb begin
    ext_s              = {MAX_DATA_W{1'b0}};
    ext_s[DATA_W-1:0]  = data;
    mode_s             = parity_mode_e'(mode_odd);
    par                = gen_parity(ext_s, mode_s);
  end

endmodule

// File: rtl/parity_gen_check.sv
// Parity generator/checker with a one-deep registered output stage,
// valid/ready flow control and a saturating mismatch counter plus sticky flag.
module parity_gen_check
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_gen_check_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $error("parity_gen_check: DATA_W out of range 1..64");
  end
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("parity_gen_check: CNT_W out of range 2..32");
  end

  logic              gen_par_s;
  logic              mismatch_s;
  logic              in_ready_s;
  logic              xfer_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_par_r;
  logic              out_err_r;
  logic [CNT_W-1:0]  err_cnt_r;
  logic              err_sticky_r;

  parity_calc #(
    .DATA_W (DATA_W)
  ) u_parity_calc (
    .data     (bus.in_data),
    .mode_odd (bus.mode_odd),
    .par      (gen_par_s)
  );

  // Handshake: the output register can take a word when empty or draining.
  always_comb begin
    in_ready_s = (~out_valid_r) | bus.out_ready;
    xfer_s     = bus.in_valid & in_ready_s;
    mismatch_s = bus.in_par ^ gen_par_s;
  end

  // Output register: load on a transfer, empty when drained, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_par_r   <= 1'b0;
      out_err_r   <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= bus.in_data;
      out_par_r   <= gen_par_s;
      out_err_r   <= mismatch_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_par_r   <= out_par_r;
      out_err_r   <= out_err_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_par_r   <= out_par_r;
      out_err_r   <= out_err_r;
    end
  end

  // Error statistics: clear wins over a same-edge mismatch; counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r    <= {CNT_W{1'b0}};
      err_sticky_r <= 1'b0;
    end else if (bus.clr_err) begin
      err_cnt_r    <= {CNT_W{1'b0}};
      err_sticky_r <= 1'b0;
    end else if (xfer_s && mismatch_s) begin
      err_sticky_r <= 1'b1;
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end else begin
      err_cnt_r    <= err_cnt_r;
      err_sticky_r <= err_sticky_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = out_data_r;
  assign bus.out_par    = out_par_r;
  assign bus.out_err    = out_err_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.err_sticky = err_sticky_r;

endmodule

// File: tb/tb_parity_gen_check.sv
// Directed bench for parity_gen_check: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation case.
module tb_parity_gen_check;
  import parity_pkg::*;

  logic clk;
  logic rst;

  parity_gen_check_if #(.DATA_W(8), .CNT_W(16)) bus ();
  parity_gen_check_if #(.DATA_W(8), .CNT_W(2))  bus_sat ();

  assign bus_sat.mode_odd  = bus.mode_odd;
  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.in_data   = bus.in_data;
  assign bus_sat.in_par    = bus.in_par;
  assign bus_sat.out_ready = bus.out_ready;
  assign bus_sat.clr_err   = bus.clr_err;

  parity_gen_check #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  parity_gen_check #(.DATA_W(8), .CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_sat)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode, data, in_par, expected out_par, expected out_err, expected counts
  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       par;
    logic       exp_par;
    logic       exp_err;
    logic [15:0] exp_cnt;
    logic [1:0] exp_sat;
  } vec_t;

  vec_t vecs [5];
  logic [7:0] words [3];
  logic [7:0] got [$];
  logic [1:0] sat_seq [5];

  initial begin
    int idx;
    logic acc;

    vecs[0] = '{1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 16'd1, 2'd1};
    vecs[1] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 16'd1, 2'd1};
    vecs[2] = '{1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 16'd2, 2'd2};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 16'd3, 2'd3};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd3, 2'd3};
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
    sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

    rst           = 1'b1;
    bus.mode_odd  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_par    = 1'b0;
    bus.out_ready = 1'b0;
    bus.clr_err   = 1'b0;

    // Reset state
    step(); step();
    check_value("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_value("rst_out_data", 64'(bus.out_data), 64'd0);
    check_value("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check_value("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
    rst = 1'b0;
    #1;
    check_value("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Even mode 0xA5, correct parity
    bus.out_ready = 1'b1;
    bus.mode_odd  = 1'b0;
    bus.in_data   = 8'hA5;
    bus.in_par    = 1'b0;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    check_value("a5_out_valid", 64'(bus.out_valid), 64'd1);
    check_value("a5_out_data", 64'(bus.out_data), 64'hA5);
    check_value("a5_out_par", 64'(bus.out_par), 64'd0);
    check_value("a5_out_err", 64'(bus.out_err), 64'd0);
    check_value("a5_err_cnt", 64'(bus.err_cnt), 64'd0);

    // Odd mode 0x01 with in_par=1 is a mismatch
    bus.mode_odd = 1'b1;
    bus.in_data  = 8'h01;
    bus.in_par   = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_value("odd01_out_par", 64'(bus.out_par), 64'd0);
    check_value("odd01_out_err", 64'(bus.out_err), 64'd1);
    check_value("odd01_err_cnt", 64'(bus.err_cnt), 64'd1);
    check_value("odd01_err_sticky", 64'(bus.err_sticky), 64'd1);
    step();
    check_value("drain_out_valid", 64'(bus.out_valid), 64'd0);
    check_value("idle_err_cnt", 64'(bus.err_cnt), 64'd1);

    // Back-to-back words with mode changes between them
    for (int i = 0; i < 5; i++) begin
      bus.mode_odd = vecs[i].mode;
      bus.in_data  = vecs[i].data;
      bus.in_par   = vecs[i].par;
      bus.in_valid = 1'b1;
      step();
      check_value($sformatf("vec%0d_data", i), 64'(bus.out_data), 64'(vecs[i].data));
      check_value($sformatf("vec%0d_par", i), 64'(bus.out_par), 64'(vecs[i].exp_par));
      check_value($sformatf("vec%0d_err", i), 64'(bus.out_err), 64'(vecs[i].exp_err));
      check_value($sformatf("vec%0d_cnt", i), 64'(bus.err_cnt), 64'(vecs[i].exp_cnt));
      check_value($sformatf("vec%0d_sat", i), 64'(bus_sat.err_cnt), 64'(vecs[i].exp_sat));
    end
    bus.in_valid = 1'b0;

    // Clear with no transfer
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check_value("clr_err_cnt", 64'(bus.err_cnt), 64'd0);
    check_value("clr_err_sticky", 64'(bus.err_sticky), 64'd0);

    // Back-pressure: output holds, in_ready drops, then in-order delivery
    bus.mode_odd  = 1'b0;
    bus.in_par    = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = words[0];
    step();
    bus.in_data   = words[1];
    for (int i = 0; i < 3; i++) begin
      check_value("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_value("bp_hold_data", 64'(bus.out_data), 64'h11);
      check_value("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      step();
    end
    idx = 1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got.size() < 3; cyc++) begin
      #1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      acc = bus.in_valid & bus.in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) bus.in_data = words[idx];
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check_value("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) check_value($sformatf("bp_word%0d", i), 64'(got[i]), 64'(words[i]));
    end
    check_value("bp_no_err", 64'(bus.err_cnt), 64'd0);

    // Saturation of the CNT_W=2 instance
    bus.mode_odd = 1'b0;
    bus.in_data  = 8'h01;
    bus.in_par   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_value($sformatf("sat_cnt%0d", i), 64'(bus_sat.err_cnt), 64'(sat_seq[i]));
      check_value($sformatf("wide_cnt%0d", i), 64'(bus.err_cnt), 64'(i + 1));
    end

    // Clear on the same edge as a mismatching transfer
    bus.clr_err = 1'b1;
    step();
    bus.clr_err  = 1'b0;
    bus.in_valid = 1'b0;
    check_value("clrx_err_cnt", 64'(bus.err_cnt), 64'd0);
    check_value("clrx_sat_cnt", 64'(bus_sat.err_cnt), 64'd0);
    check_value("clrx_sticky", 64'(bus.err_sticky), 64'd0);
    check_value("clrx_out_err", 64'(bus.out_err), 64'd1);

    // Reset between edges with a word in flight
    bus.mode_odd = 1'b0;
    bus.in_data  = 8'h01;
    bus.in_par   = 1'b0;
    bus.in_valid = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    check_value("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_value("mid_rst_out_data", 64'(bus.out_data), 64'd0);
    check_value("mid_rst_out_par", 64'(bus.out_par), 64'd0);
    check_value("mid_rst_out_err", 64'(bus.out_err), 64'd0);
    check_value("mid_rst_err_cnt", 64'(bus.err_cnt), 64'd0);
    check_value("mid_rst_sticky", 64'(bus.err_sticky), 64'd0);
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_value("rel_in_ready", 64'(bus.in_ready), 64'd1);
    check_value("rel_out_valid", 64'(bus.out_valid), 64'd0);
    bus.mode_odd = 1'b1;
    bus.in_data  = 8'h0F;
    bus.in_par   = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check_value("first_out_valid", 64'(bus.out_valid), 64'd1);
    check_value("first_out_data", 64'(bus.out_data), 64'h0F);
    check_value("first_out_par", 64'(bus.out_par), 64'd1);
    check_value("first_out_err", 64'(bus.out_err), 64'd0);
    check_value("first_err_cnt", 64'(bus.err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
